// File: rtl/pwm_capture.sv
// PWM capture: measures period (as cycles-1) and high time of an asynchronous
// PWM input in clk cycles, using the same encoding as the pwm generator.
module pwm_capture #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] pulse_width_out,
    output logic             meas_valid,
    output logic             overflow,
    output logic             static_high,
    output logic             static_low
);

    localparam int unsigned CW = WIDTH + 1;
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_prev_q;
    logic                   lvl;
    logic                   rise;
    logic                   fall;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    hcnt_q, hcnt_d;
    logic             fell_q, fell_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] pw_q, pw_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             sh_q, sh_d;
    logic             sl_q, sl_d;

    // Synchroniser plus edge-detect flop; runs independently of enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            lvl_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = lvl & ~lvl_prev_q;
    assign fall = ~lvl & lvl_prev_q;

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            fell_q   <= 1'b0;
            period_q <= '0;
            pw_q     <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            fell_q   <= fell_d;
            period_q <= period_d;
            pw_q     <= pw_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            sh_q     <= sh_d;
            sl_q     <= sl_d;
        end
    end

    // Next-state logic. A rise in ARM or MEASURE opens a new window with the
    // rise cycle itself counted as cycle 1 (and as one high cycle).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        fell_d   = fell_q;
        period_d = period_q;
        pw_d     = pw_q;
        valid_d  = 1'b0;
        ovf_d    = 1'b0;
        sh_d     = sh_q;
        sl_d     = sl_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            fell_d  = 1'b0;
            sh_d    = 1'b0;
            sl_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    fell_d  = 1'b0;
                    sh_d    = 1'b0;
                    sl_d    = 1'b0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CW'(1);
                        hcnt_d  = CW'(1);
                        fell_d  = 1'b0;
                        sh_d    = 1'b0;
                        sl_d    = 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        valid_d  = 1'b1;
                        period_d = WIDTH'(cnt_q - CW'(1));
                        pw_d     = WIDTH'(hcnt_q);
                        cnt_d    = CW'(1);
                        hcnt_d   = CW'(1);
                        fell_d   = 1'b0;
                        sh_d     = 1'b0;
                        sl_d     = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        ovf_d   = 1'b1;
                        sh_d    = ~(fell_q | fall);
                        sl_d    = fell_q | fall;
                        cnt_d   = '0;
                        hcnt_d  = '0;
                        fell_d  = 1'b0;
                        state_d = ARM;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        hcnt_d = hcnt_q + CW'(lvl);
                        fell_d = fell_q | fall;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign period_out      = period_q;
    assign pulse_width_out = pw_q;
    assign meas_valid      = valid_q;
    assign overflow        = ovf_q;
    assign static_high     = sh_q;
    assign static_low      = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pwm_capture;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SYNC  = 2;
    localparam int          PMAX  = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pwm_in;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] pulse_width_out;
    logic             meas_valid;
    logic             overflow;
    logic             static_high;
    logic             static_low;

    pwm_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .pwm_in          (pwm_in),
        .period_out      (period_out),
        .pulse_width_out (pulse_width_out),
        .meas_valid      (meas_valid),
        .overflow        (overflow),
        .static_high     (static_high),
        .static_low      (static_low)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: delayed input history plus window start timestamp.
    int  cyc = 0;
    bit  hist [SYNC+1];
    int  mode = 0;          // 0 idle, 1 waiting for rise, 2 inside a window
    int  t_rise = 0;
    int  hi_cnt = 0;
    bit  fell_seen = 0;
    int  e_per = 0, e_pw = 0;
    bit  e_valid = 0, e_ovf = 0, e_sh = 0, e_sl = 0;

    int  n_valid = 0, n_ovf = 0, n_sl = 0, ovf_gap = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit p);
        bit lvl, prv, rise, fall;
        cyc++;
        e_valid = 0;
        e_ovf   = 0;
        if (!r) begin
            for (int i = 0; i <= SYNC; i++) hist[i] = 0;
            mode = 0; hi_cnt = 0; fell_seen = 0;
            e_per = 0; e_pw = 0; e_sh = 0; e_sl = 0;
            return;
        end
        lvl  = hist[SYNC-1];
        prv  = hist[SYNC];
        rise = lvl && !prv;
        fall = !lvl && prv;
        if (!e) begin
            mode = 0; e_sh = 0; e_sl = 0;
        end else if (mode == 0) begin
            mode = 1;
        end else begin
            if (mode == 2 && !rise && (cyc - t_rise) == PMAX) begin
                e_ovf = 1;
                e_sh  = !(fell_seen || fall);
                e_sl  = fell_seen || fall;
                mode  = 1;
            end else if (rise) begin
                if (mode == 2) begin
                    e_valid = 1;
                    e_per   = cyc - t_rise - 1;
                    e_pw    = hi_cnt;
                end
                t_rise = cyc; hi_cnt = 0; fell_seen = 0; mode = 2;
                e_sh = 0; e_sl = 0;
            end else if (mode == 2) begin
                fell_seen = fell_seen || fall;
            end
            if (mode == 2) hi_cnt += int'(lvl);
        end
        hist[SYNC] = lvl;
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = p;
    endtask

    task automatic tick(input bit r, input bit e, input bit p);
        rst_n  = r;
        enable = e;
        pwm_in = p;
        @(posedge clk);
        #1;
        model_step(r, e, p);
        chk("period_out", int'(period_out), e_per);
        chk("pulse_width_out", int'(pulse_width_out), e_pw);
        chk("meas_valid", int'(meas_valid), int'(e_valid));
        chk("overflow", int'(overflow), int'(e_ovf));
        chk("static_high", int'(static_high), int'(e_sh));
        chk("static_low", int'(static_low), int'(e_sl));
        if (meas_valid) n_valid++;
        if (static_low) n_sl++;
        if (overflow) begin
            n_ovf++;
            ovf_gap = cyc - t_rise + 1;
        end
    endtask

    task automatic gen(input int per, input int hi, input int nper);
        for (int k = 0; k < nper; k++)
            for (int i = 0; i < per; i++)
                tick(1, 1, i < hi);
    endtask

    task automatic clr_stats();
        n_valid = 0; n_ovf = 0; n_sl = 0; ovf_gap = 0;
    endtask

    initial begin
        for (int i = 0; i <= SYNC; i++) hist[i] = 0;
        rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;

        repeat (3) tick(0, 0, 0);
        chk("rst_period", int'(period_out), 0);
        chk("rst_valid", int'(meas_valid), 0);

        // Steady 10/3 waveform.
        clr_stats();
        gen(10, 3, 8);
        chk("p10_period", int'(period_out), 9);
        chk("p10_width", int'(pulse_width_out), 3);
        chk("p10_nvalid", n_valid, 7);
        chk("p10_novf", n_ovf, 0);

        // Stuck high after a rise.
        clr_stats();
        repeat (300) tick(1, 1, 1);
        chk("sh_novf", n_ovf, 1);
        chk("sh_gap", ovf_gap, 257);
        chk("sh_flag", int'(static_high), 1);
        chk("sh_hold_period", int'(period_out), 9);
        clr_stats();
        gen(10, 3, 4);
        chk("sh_clear", int'(static_high), 0);
        chk("sh_resume_nvalid", n_valid, 2);
        chk("sh_resume_width", int'(pulse_width_out), 3);

        // Longest legal period, then one cycle too long, then stuck low.
        clr_stats();
        gen(256, 1, 3);
        chk("p256_period", int'(period_out), 255);
        chk("p256_width", int'(pulse_width_out), 1);
        chk("p256_novf", n_ovf, 0);
        clr_stats();
        gen(257, 1, 2);
        repeat (300) tick(1, 1, 0);
        chk("p257_novf", n_ovf, 2);
        chk("p257_sl", int'(static_low), 1);
        chk("p257_sh", int'(static_high), 0);
        chk("p257_hold_period", int'(period_out), 255);
        chk("p257_nsl", int'(n_sl >= 2), 1);

        // Minimum high pulse.
        gen(5, 1, 6);
        chk("min_period", int'(period_out), 4);
        chk("min_width", int'(pulse_width_out), 1);
        chk("min_sl_clear", int'(static_low), 0);

        // Enable dropped mid-high, re-enabled while input still high.
        gen(10, 3, 3);
        clr_stats();
        tick(1, 1, 1);
        repeat (2) tick(1, 0, 1);
        repeat (2) tick(1, 1, 1);
        gen(10, 3, 3);
        chk("abort_nvalid", n_valid, 1);
        chk("abort_novf", n_ovf, 0);

        // Reset pulse mid-measurement.
        gen(10, 3, 2);
        repeat (2) tick(1, 1, 1);
        tick(0, 1, 0);
        chk("mrst_period", int'(period_out), 0);
        chk("mrst_width", int'(pulse_width_out), 0);
        clr_stats();
        gen(10, 3, 3);
        chk("mrst_nvalid", n_valid, 2);

        // Randomised waveforms with occasional enable drops and stalls.
        for (int it = 0; it < 40; it++) begin
            int per, hi;
            per = int'($urandom_range(2, 40));
            hi  = int'($urandom_range(1, per - 1));
            gen(per, hi, int'($urandom_range(1, 5)));
            if ($urandom_range(0, 7) == 0) tick(1, 0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) repeat (270) tick(1, 1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures the period and high time of an incoming PWM waveform (the receive-side counterpart of the team's pwm generator) in clk cycles.
- Reports results in the generator's encoding: period = cycles-per-cycle minus 1, pulse_width = high cycles. A captured waveform can therefore be fed straight back into a generator.
- Sits on the input side of motor/servo feedback paths. Also used as a loopback checker for generator outputs.

Parameters:
- WIDTH, 8, width of period_out/pulse_width_out; maximum measurable period is 2^WIDTH cycles.
- SYNC_STAGES, 2, number of synchroniser flops on pwm_in (minimum 2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: synchronous, active-low.
- enable  input  1  1 = capture running; 0 = idle.
- pwm_in  input  1  asynchronous PWM input.
- period_out  output  WIDTH  last measured period, encoded as cycles-1.
- pulse_width_out  output  WIDTH  last measured high time, in cycles.
- meas_valid  output  1  one-cycle pulse when period_out/pulse_width_out update.
- overflow  output  1  one-cycle pulse when no rising edge arrives within 2^WIDTH cycles.
- static_high  output  1  input stuck high (100% duty) after overflow.
- static_low  output  1  input stuck low (0% duty) after overflow.

Behaviour:
- Reset: all outputs, synchroniser flops, counters and state go to 0 / IDLE on the first clk edge with rst_n=0. Reset mid-measurement discards the partial measurement.
- Synchroniser: pwm_in passes through SYNC_STAGES flops, then one more flop for edge detection.
  - Rise = sync 1 and previous 0; fall = sync 1→0.
  - Both edges see the same delay, so measurements are unaffected.
  - The synchroniser runs regardless of enable.
- Definitions, from one rise detect at cycle t0 to the next at t0+P:
  - P = cycles between the two rises.
  - H = cycles the synchronised level was 1 within that window.
  - Results: period_out = P-1, pulse_width_out = H.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: counters cleared; static_* cleared. enable=1 → ARM.
  - ARM: wait for a rise; rise → MEASURE, counting from t0. A level that is already high on entry is not an edge.
  - MEASURE, rise at t0+P with P ≤ 2^WIDTH: register results and pulse meas_valid on cycle t0+P+1. That same rise opens the next window (back-to-back, no lost period).
  - MEASURE, no rise at t0+2^WIDTH: pulse overflow on cycle t0+2^WIDTH+1, then go to ARM.
    - No fall since t0: set static_high.
    - Fall seen: set static_low.
  - enable=0 in any state → IDLE next cycle; no meas_valid or overflow is issued for the aborted window.
- Output holding: period_out/pulse_width_out hold their last values through overflow, IDLE and re-arm; they change only with meas_valid or reset.
- static_high/static_low: at most one is set at a time; both clear on the next rise detect or in IDLE.
- Counter width: the internal counter must represent 2^WIDTH (WIDTH+1 bits).
  - P = 2^WIDTH → period_out = all ones, legal with no overflow.
  - H ≤ P-1 always, since a low phase is required to form a second rise.
- Multiple falls cannot occur without an intervening rise. The minimum legal input is 1 high cycle / 1 low cycle: P=2, H=1 → period_out=1.

Test Plan:
- Continuous generator-style input, 10-cycle period, 3 high (WIDTH=8) → first meas_valid one cycle after the second rise, then every 10 cycles; period_out=9, pulse_width_out=3, overflow never asserts.
- pwm_in held 1 after one rise → overflow pulse exactly 257 cycles after the rise detect, static_high=1, no meas_valid. Resume 10/3 toggling → static_high clears at the first rise; valid after the next rise with 9/3.
- Boundary: P=256, H=1 → meas_valid, period_out=255, pulse_width_out=1, no overflow. P=257 → overflow plus static_low, prior outputs unchanged.
- Minimum pulse: 1 high, 4 low, repeating → period_out=4, pulse_width_out=1 on every valid.
- Deassert enable mid-high, re-enable while pwm_in=1 → no valid or overflow for the aborted window; capture waits for the next rise and needs a full window before meas_valid.
- rst_n=0 for 1 cycle mid-measurement → all outputs 0 the next cycle; next meas_valid only after two fresh rises.
